// File: rtl/dac_channel_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// dac_channel_scheduler_pkg
// Shared definitions for the two-channel DAC scheduler:
//   - default sample width and Busy timeout
//   - DAC channel encodings (CH_A = DAC0/A, CH_B = DAC1/B)
//   - scheduler FSM state encoding
//   - round-robin grant helper
// -----------------------------------------------------------------------------
package dac_channel_scheduler_pkg;

   localparam int DAC_WIDTH            = 10;
   localparam int BUSY_TIMEOUT_DEFAULT = 64;

   localparam logic CH_A = 1'b0;
   localparam logic CH_B = 1'b1;

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_ISSUE     = 2'd1,
      S_WAIT_BUSY = 2'd2,
      S_WAIT_DONE = 2'd3
   } sched_state_e;

   // Round-robin pick: a lone pending channel wins outright; on a tie the
   // channel that was not granted last time wins.
   function automatic logic rr_pick(input logic pend_a,
                                    input logic pend_b,
                                    input logic last_grant);
      logic pick;
      if (pend_a && pend_b) begin
         pick = ~last_grant;
      end else if (pend_b) begin
         pick = CH_B;
      end else begin
         pick = CH_A;
      end
      return pick;
   endfunction

endpackage

// File: rtl/dac_req_slot.sv
// -----------------------------------------------------------------------------
// dac_req_slot
// One-deep pending-sample slot for a single DAC channel.
// Ports:
//   clk, reset   : system clock, synchronous active-high reset
//   strobe       : capture data as the pending sample
//   data         : sample to capture
//   consume      : scheduler is issuing the pending sample this cycle
//   clear_flags  : clear the sticky overrun flag
//   pending      : a sample is waiting to be issued
//   q            : the pending (or most recently issued) sample
//   overrun      : sticky, a pending sample was overwritten before issue
// -----------------------------------------------------------------------------
module dac_req_slot
   import dac_channel_scheduler_pkg::*;
#(
   parameter int WIDTH = DAC_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             strobe,
   input  logic [WIDTH-1:0] data,
   input  logic             consume,
   input  logic             clear_flags,
   output logic             pending,
   output logic [WIDTH-1:0] q,
   output logic             overrun
);

   logic             pending_q, pending_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             overrun_q, overrun_d;

   // Next-state for the slot. A strobe coinciding with consume refills the
   // slot (the old value is what gets issued) and is not an overrun.
   always_comb begin
      pending_d = pending_q;
      data_d    = data_q;
      overrun_d = overrun_q;

      if (strobe) begin
         pending_d = 1'b1;
         data_d    = data;
      end else if (consume) begin
         pending_d = 1'b0;
      end else begin
         pending_d = pending_q;
      end

      // Setting beats clearing when both happen in the same cycle.
      if (strobe && pending_q && !consume) begin
         overrun_d = 1'b1;
      end else if (clear_flags) begin
         overrun_d = 1'b0;
      end else begin
         overrun_d = overrun_q;
      end
   end

   // Slot state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         pending_q <= 1'b0;
         data_q    <= '0;
         overrun_q <= 1'b0;
      end else begin
         pending_q <= pending_d;
         data_q    <= data_d;
         overrun_q <= overrun_d;
      end
   end

   assign pending = pending_q;
   assign q       = data_q;
   assign overrun = overrun_q;

endmodule

// File: rtl/dac_channel_scheduler.sv
// -----------------------------------------------------------------------------
// dac_channel_scheduler
// Shares one two-channel DAC front end between two sample sources. Each
// channel has a one-deep pending slot; a round-robin arbiter picks which
// pending sample is written next, and an FSM issues a one-cycle write and
// follows the DAC Busy handshake through the conversion.
// Ports:
//   clk_50MHZ, reset        : system clock, synchronous active-high reset
//   wr0_strobe/wr0_data     : ch0 sample write
//   wr1_strobe/wr1_data     : ch1 sample write
//   clear_flags             : clear overrun0/overrun1/timeout_err
//   dac_busy                : Busy from the DAC interface
//   dac_trigger             : one-cycle DAC write strobe
//   dac_channel/dac_din     : channel select and data, held until next write
//   done0/done1             : one-cycle conversion-complete pulses
//   overrun0/overrun1       : sticky pending-sample-overwritten flags
//   timeout_err             : sticky, Busy never rose after a write
//   idle                    : FSM idle and nothing pending
// -----------------------------------------------------------------------------
module dac_channel_scheduler
   import dac_channel_scheduler_pkg::*;
#(
   parameter int WIDTH        = DAC_WIDTH,
   parameter int BUSY_TIMEOUT = BUSY_TIMEOUT_DEFAULT
) (
   input  logic             clk_50MHZ,
   input  logic             reset,
   input  logic             wr0_strobe,
   input  logic [WIDTH-1:0] wr0_data,
   input  logic             wr1_strobe,
   input  logic [WIDTH-1:0] wr1_data,
   input  logic             clear_flags,
   input  logic             dac_busy,
   output logic             dac_trigger,
   output logic             dac_channel,
   output logic [WIDTH-1:0] dac_din,
   output logic             done0,
   output logic             done1,
   output logic             overrun0,
   output logic             overrun1,
   output logic             timeout_err,
   output logic             idle
);

   localparam int            CW       = $clog2(BUSY_TIMEOUT);
   localparam logic [CW-1:0] CNT_LAST = CW'(BUSY_TIMEOUT - 1);
   localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

   sched_state_e     state_q;
   logic             trigger_q;
   logic             channel_q;
   logic [WIDTH-1:0] din_q;
   logic             done0_q, done1_q;
   logic             timeout_q;
   logic             idle_q;
   logic             last_grant_q;
   logic [CW-1:0]    cnt_q;

   logic             pend0, pend1;
   logic [WIDTH-1:0] q0, q1;
   logic             consume0_d, consume1_d;
   logic             issue_go_d;
   logic             grant_ch_d;
   logic [WIDTH-1:0] grant_din_d;
   logic [CW-1:0]    cnt_inc_d;
   logic             timeout_hit_d;
   logic             to_idle_d;
   logic             pend0_next_d, pend1_next_d;

   dac_req_slot #(.WIDTH(WIDTH)) u_slot0 (
      .clk         (clk_50MHZ),
      .reset       (reset),
      .strobe      (wr0_strobe),
      .data        (wr0_data),
      .consume     (consume0_d),
      .clear_flags (clear_flags),
      .pending     (pend0),
      .q           (q0),
      .overrun     (overrun0)
   );

   dac_req_slot #(.WIDTH(WIDTH)) u_slot1 (
      .clk         (clk_50MHZ),
      .reset       (reset),
      .strobe      (wr1_strobe),
      .data        (wr1_data),
      .consume     (consume1_d),
      .clear_flags (clear_flags),
      .pending     (pend1),
      .q           (q1),
      .overrun     (overrun1)
   );

   // Arbitration, timeout detection and next-idle prediction.
   always_comb begin
      issue_go_d    = 1'b0;
      grant_ch_d    = CH_A;
      grant_din_d   = q0;
      consume0_d    = 1'b0;
      consume1_d    = 1'b0;
      cnt_inc_d     = cnt_q;
      timeout_hit_d = 1'b0;
      to_idle_d     = 1'b0;

      // A new write only starts once the DAC has dropped Busy, which also
      // covers a reset that aborted a conversion still in flight.
      if ((state_q == S_IDLE) && !dac_busy && (pend0 || pend1)) begin
         issue_go_d = 1'b1;
         grant_ch_d = rr_pick(pend0, pend1, last_grant_q);
      end else begin
         issue_go_d = 1'b0;
         grant_ch_d = CH_A;
      end

      if (grant_ch_d == CH_B) begin
         grant_din_d = q1;
      end else begin
         grant_din_d = q0;
      end

      consume0_d = issue_go_d && (grant_ch_d == CH_A);
      consume1_d = issue_go_d && (grant_ch_d == CH_B);

      // Saturating increment; the counter never wraps.
      if (cnt_q == CNT_MAX) begin
         cnt_inc_d = cnt_q;
      end else begin
         cnt_inc_d = cnt_q + CW'(1);
      end

      timeout_hit_d = (state_q == S_WAIT_BUSY) && !dac_busy && (cnt_inc_d == CNT_LAST);

      case (state_q)
         S_IDLE:      to_idle_d = !issue_go_d;
         S_ISSUE:     to_idle_d = 1'b0;
         S_WAIT_BUSY: to_idle_d = timeout_hit_d;
         S_WAIT_DONE: to_idle_d = !dac_busy;
         default:     to_idle_d = 1'b1;
      endcase

      pend0_next_d = wr0_strobe || (pend0 && !consume0_d);
      pend1_next_d = wr1_strobe || (pend1 && !consume1_d);
   end

   // Scheduler FSM with registered DAC strobes and status outputs.
   always_ff @(posedge clk_50MHZ) begin
      if (reset) begin
         state_q      <= S_IDLE;
         trigger_q    <= 1'b0;
         channel_q    <= CH_A;
         din_q        <= '0;
         done0_q      <= 1'b0;
         done1_q      <= 1'b0;
         timeout_q    <= 1'b0;
         idle_q       <= 1'b1;
         last_grant_q <= CH_B;
         cnt_q        <= '0;
      end else begin
         trigger_q <= 1'b0;
         done0_q   <= 1'b0;
         done1_q   <= 1'b0;
         idle_q    <= to_idle_d && !pend0_next_d && !pend1_next_d;

         // A timeout in the same cycle as clear_flags keeps the flag set.
         if (timeout_hit_d) begin
            timeout_q <= 1'b1;
         end else if (clear_flags) begin
            timeout_q <= 1'b0;
         end else begin
            timeout_q <= timeout_q;
         end

         case (state_q)
            S_IDLE: begin
               if (issue_go_d) begin
                  state_q      <= S_ISSUE;
                  trigger_q    <= 1'b1;
                  channel_q    <= grant_ch_d;
                  din_q        <= grant_din_d;
                  last_grant_q <= grant_ch_d;
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_ISSUE: begin
               state_q <= S_WAIT_BUSY;
               cnt_q   <= '0;
            end
            S_WAIT_BUSY: begin
               if (dac_busy) begin
                  state_q <= S_WAIT_DONE;
               end else if (timeout_hit_d) begin
                  state_q <= S_IDLE;
               end else begin
                  cnt_q <= cnt_inc_d;
               end
            end
            S_WAIT_DONE: begin
               if (!dac_busy) begin
                  state_q <= S_IDLE;
                  done0_q <= (channel_q == CH_A);
                  done1_q <= (channel_q == CH_B);
               end else begin
                  state_q <= S_WAIT_DONE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign dac_trigger = trigger_q;
   assign dac_channel = channel_q;
   assign dac_din     = din_q;
   assign done0       = done0_q;
   assign done1       = done1_q;
   assign timeout_err = timeout_q;
   assign idle        = idle_q;

endmodule

// File: tb/tb_dac_channel_scheduler.sv
// -----------------------------------------------------------------------------
// tb_dac_channel_scheduler
// Directed bench for dac_channel_scheduler with a DAC Busy model that holds
// Busy high for 18 cycles after each accepted write.
// -----------------------------------------------------------------------------
module tb_dac_channel_scheduler;

   logic       clk = 1'b0;
   logic       reset;
   logic       wr0_strobe, wr1_strobe, clear_flags;
   logic [9:0] wr0_data, wr1_data;
   logic       dac_busy;
   logic       dac_trigger, dac_channel, done0, done1;
   logic       overrun0, overrun1, timeout_err, idle;
   logic [9:0] dac_din;

   int n_checks = 0;
   int n_errors = 0;
   int done0_cnt = 0;
   int done1_cnt = 0;
   int stale_010 = 0;
   int busy_cnt = 0;
   logic model_en = 1'b1;

   always #5 clk = ~clk;

   dac_channel_scheduler #(.WIDTH(10), .BUSY_TIMEOUT(64)) dut (
      .clk_50MHZ   (clk),
      .reset       (reset),
      .wr0_strobe  (wr0_strobe),
      .wr0_data    (wr0_data),
      .wr1_strobe  (wr1_strobe),
      .wr1_data    (wr1_data),
      .clear_flags (clear_flags),
      .dac_busy    (dac_busy),
      .dac_trigger (dac_trigger),
      .dac_channel (dac_channel),
      .dac_din     (dac_din),
      .done0       (done0),
      .done1       (done1),
      .overrun0    (overrun0),
      .overrun1    (overrun1),
      .timeout_err (timeout_err),
      .idle        (idle)
   );

   // DAC model: Busy high for 18 cycles starting the cycle after a trigger.
   always @(posedge clk) begin
      if (model_en && dac_trigger) busy_cnt <= 18;
      else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
   end
   assign dac_busy = (busy_cnt != 0);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Background monitor: write/busy invariant, done pulse counting.
   always @(negedge clk) begin
      if (dac_trigger) begin
         check("trig_while_busy", {31'd0, dac_busy}, 32'd0);
         if (dac_channel && dac_din == 10'h010) stale_010++;
      end
      if (done0) done0_cnt++;
      if (done1) done1_cnt++;
   end

   task automatic tick();
      @(negedge clk);
   endtask

   function automatic logic pick(input int sel);
      case (sel)
         0: return dac_trigger;
         1: return done0;
         2: return done1;
         3: return timeout_err;
         4: return idle;
         default: return 1'b0;
      endcase
   endfunction

   task automatic wait_sig(input int sel, input int max, input string tag, output int n);
      n = 0;
      while (!pick(sel) && n < max) begin
         tick();
         n++;
      end
      if (!pick(sel)) check({tag, "_expired"}, 32'd0, 32'd1);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_trig"}, {31'd0, dac_trigger}, 32'd0);
      check({tag, "_chan"}, {31'd0, dac_channel}, 32'd0);
      check({tag, "_din"},  {22'd0, dac_din}, 32'd0);
      check({tag, "_done"}, {30'd0, done1, done0}, 32'd0);
      check({tag, "_ovr"},  {30'd0, overrun1, overrun0}, 32'd0);
      check({tag, "_tmo"},  {31'd0, timeout_err}, 32'd0);
      check({tag, "_idle"}, {31'd0, idle}, 32'd1);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic pulse_clear();
      clear_flags = 1'b1;
      tick();
      clear_flags = 1'b0;
   endtask

   initial begin
      int n;
      int snap0, snap1;
      logic chs[10];

      reset = 1'b1;
      wr0_strobe = 1'b0; wr1_strobe = 1'b0; clear_flags = 1'b0;
      wr0_data = 10'h000; wr1_data = 10'h000;
      tick(); tick(); tick();
      check_reset_vals("rst");
      reset = 1'b0;
      tick();

      // 1. Single write on ch0.
      wr0_strobe = 1'b1; wr0_data = 10'h155;
      tick();
      wr0_strobe = 1'b0;
      check("t1_no_early_trig", {31'd0, dac_trigger}, 32'd0);
      check("t1_not_idle", {31'd0, idle}, 32'd0);
      tick();
      check("t1_trig", {31'd0, dac_trigger}, 32'd1);
      check("t1_chan", {31'd0, dac_channel}, 32'd0);
      check("t1_din", {22'd0, dac_din}, 32'h155);
      wait_sig(1, 30, "t1_done0", n);
      check("t1_done_lat", n, 32'd20);
      check("t1_idle", {31'd0, idle}, 32'd1);
      check("t1_din_held", {22'd0, dac_din}, 32'h155);
      tick();

      // 2. Simultaneous strobes after reset: ch0 first, then ch1.
      do_reset();
      snap0 = done0_cnt; snap1 = done1_cnt;
      wr0_strobe = 1'b1; wr0_data = 10'h001;
      wr1_strobe = 1'b1; wr1_data = 10'h3FF;
      tick();
      wr0_strobe = 1'b0; wr1_strobe = 1'b0;
      tick();
      check("t2_trig0", {31'd0, dac_trigger}, 32'd1);
      check("t2_chan0", {31'd0, dac_channel}, 32'd0);
      check("t2_din0", {22'd0, dac_din}, 32'h001);
      wait_sig(1, 30, "t2_done0", n);
      check("t2_done0_lat", n, 32'd20);
      tick();
      check("t2_trig1", {31'd0, dac_trigger}, 32'd1);
      check("t2_chan1", {31'd0, dac_channel}, 32'd1);
      check("t2_din1", {22'd0, dac_din}, 32'h3FF);
      wait_sig(2, 30, "t2_done1", n);
      check("t2_done1_lat", n, 32'd20);
      tick();
      check("t2_done0_cnt", done0_cnt - snap0, 32'd1);
      check("t2_done1_cnt", done1_cnt - snap1, 32'd1);
      check("t2_no_ovr", {30'd0, overrun1, overrun0}, 32'd0);

      // 3. Overrun on ch1 while ch0 converts.
      wr0_strobe = 1'b1; wr0_data = 10'h0AA;
      tick();
      wr0_strobe = 1'b0;
      wr1_strobe = 1'b1; wr1_data = 10'h010;
      tick();
      wr1_strobe = 1'b0;
      check("t3_trig0", {31'd0, dac_trigger}, 32'd1);
      check("t3_chan0", {31'd0, dac_channel}, 32'd0);
      check("t3_din0", {22'd0, dac_din}, 32'h0AA);
      repeat (5) tick();
      check("t3_ovr_before", {31'd0, overrun1}, 32'd0);
      wr1_strobe = 1'b1; wr1_data = 10'h020;
      tick();
      wr1_strobe = 1'b0;
      check("t3_ovr1", {31'd0, overrun1}, 32'd1);
      check("t3_ovr0", {31'd0, overrun0}, 32'd0);
      wait_sig(1, 30, "t3_done0", n);
      tick();
      check("t3_trig1", {31'd0, dac_trigger}, 32'd1);
      check("t3_chan1", {31'd0, dac_channel}, 32'd1);
      check("t3_din1", {22'd0, dac_din}, 32'h020);
      wait_sig(2, 30, "t3_done1", n);
      check("t3_stale", stale_010, 32'd0);
      pulse_clear();
      check("t3_ovr1_clr", {31'd0, overrun1}, 32'd0);

      // 4. Fairness with both channels strobed every cycle.
      n = 0;
      wr0_strobe = 1'b1; wr1_strobe = 1'b1;
      for (int c = 0; c < 400 && n < 10; c++) begin
         wr0_data = 10'(c);
         wr1_data = 10'(c + 512);
         tick();
         if (dac_trigger) begin
            chs[n] = dac_channel;
            n++;
         end
      end
      wr0_strobe = 1'b0; wr1_strobe = 1'b0;
      check("t4_count", n, 32'd10);
      for (int i = 0; i < 10; i++) begin
         check($sformatf("t4_chan%0d", i), {31'd0, chs[i]}, 32'(i % 2));
      end
      wait_sig(4, 120, "t4_drain", n);
      pulse_clear();
      check("t4_ovr_clr", {30'd0, overrun1, overrun0}, 32'd0);

      // 5. Busy never rises: timeout, then the next pending sample goes out.
      model_en = 1'b0;
      snap0 = done0_cnt; snap1 = done1_cnt;
      wr0_strobe = 1'b1; wr0_data = 10'h123;
      tick();
      wr0_strobe = 1'b0;
      tick();
      check("t5_trig0", {31'd0, dac_trigger}, 32'd1);
      wr1_strobe = 1'b1; wr1_data = 10'h234;
      tick();
      wr1_strobe = 1'b0;
      wait_sig(3, 80, "t5_tmo", n);
      check("t5_tmo_lat", n + 1, 32'd64);
      check("t5_no_done", (done0_cnt - snap0) + (done1_cnt - snap1), 32'd0);
      model_en = 1'b1;
      tick();
      check("t5_trig1", {31'd0, dac_trigger}, 32'd1);
      check("t5_chan1", {31'd0, dac_channel}, 32'd1);
      check("t5_din1", {22'd0, dac_din}, 32'h234);
      wait_sig(2, 30, "t5_done1", n);
      check("t5_done1_lat", n, 32'd20);
      check("t5_tmo_sticky", {31'd0, timeout_err}, 32'd1);
      pulse_clear();
      check("t5_tmo_clr", {31'd0, timeout_err}, 32'd0);

      // 6. Reset during WAIT_DONE.
      snap0 = done0_cnt;
      wr0_strobe = 1'b1; wr0_data = 10'h2AA;
      tick();
      wr0_strobe = 1'b0;
      tick();
      check("t6_trig0", {31'd0, dac_trigger}, 32'd1);
      repeat (10) tick();
      reset = 1'b1;
      tick();
      check_reset_vals("t6_rst");
      reset = 1'b0;
      wr1_strobe = 1'b1; wr1_data = 10'h0F0;
      tick();
      wr1_strobe = 1'b0;
      wait_sig(0, 40, "t6_trig1", n);
      check("t6_trig_lat", n, 32'd8);
      check("t6_chan1", {31'd0, dac_channel}, 32'd1);
      check("t6_din1", {22'd0, dac_din}, 32'h0F0);
      wait_sig(2, 30, "t6_done1", n);
      tick();
      check("t6_no_done0", done0_cnt - snap0, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
